// File: rtl/rf_write_ctrl_pkg.sv
// Shared definitions for the register-file write path.
// RF_AW/RF_DW/RF_NREGS describe the 16x16 register file.
// rf_wr_entry_t is one queued write: destination address plus value.
package rf_write_ctrl_pkg;

  localparam int unsigned RF_AW    = 4;
  localparam int unsigned RF_DW    = 16;
  localparam int unsigned RF_NREGS = 16;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_entry_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// In-order write queue feeding the register-file write port.
// Ports:
//   clk, clear          clock, synchronous active-high reset
//   flush               synchronous discard of all entries
//   push, push_entry    enqueue one entry (caller guarantees not full)
//   pop                 dequeue head (caller guarantees not empty)
//   count               number of queued entries
//   head                physical slot of the oldest entry
//   head_entry          oldest entry
//   entries, valid      every physical slot and its occupancy, for the forwarding scan
module rf_wq_fifo
  import rf_write_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         flush,
  input  logic         push,
  input  rf_wr_entry_t push_entry,
  input  logic         pop,
  output logic [CW-1:0] count,
  output logic [PW-1:0] head,
  output rf_wr_entry_t head_entry,
  output rf_wr_entry_t entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  rf_wr_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] age;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (clear || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !flush) mem_q[tail_q] <= push_entry;
  end

  // A slot is live when its distance from head is below the count.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int s = 0; s < DEPTH; s++) begin
      age      = PW'(s) - head_q;
      valid[s] = ({1'b0, age} < count_q);
    end
  end

  assign entries    = mem_q;
  assign head_entry = mem_q[head_q];
  assign head       = head_q;
  assign count      = count_q;

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port initiator.
// Buffers writeback results in an in-order queue, commits one per cycle to
// the register file, and forwards the youngest queued value to the read paths.
// Ports:
//   clk, Clear, flush                      clock, sync reset, queue discard
//   in_valid/in_ready/in_addr/in_data      writeback handshake
//   wr_hold                                suppress commits this cycle
//   Caddr/C/Load                           register-file write port
//   Aaddr/Baddr, rf_a/rf_b                 read addresses and raw read data
//   A/B                                    forwarded operands
//   pending                                queued entry count
module rf_write_ctrl
  import rf_write_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = RF_AW,
  parameter int unsigned DW          = RF_DW,
  parameter bit          R0_WRITABLE = 1'b1,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned CW         = PW + 1
) (
  input  logic          clk,
  input  logic          Clear,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          wr_hold,
  output logic [AW-1:0] Caddr,
  output logic [DW-1:0] C,
  output logic          Load,
  input  logic [AW-1:0] Aaddr,
  input  logic [AW-1:0] Baddr,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [CW-1:0] pending
);

  logic          push, pop, has_entry, drop_r0;
  rf_wr_entry_t  push_entry, head_entry;
  rf_wr_entry_t  entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head, slot;

  // Ready ignores a same-cycle pop, keeping pop off the ready path.
  assign in_ready  = (pending != CW'(DEPTH)) && !Clear;
  assign drop_r0   = !R0_WRITABLE && (in_addr == '0);
  assign push      = in_valid && in_ready && !flush && !drop_r0;
  assign has_entry = (pending != '0);
  assign Load      = has_entry && !wr_hold && !Clear;
  assign pop       = Load;

  assign push_entry.addr = in_addr;
  assign push_entry.data = in_data;

  assign Caddr = (has_entry && !Clear) ? head_entry.addr : '0;
  assign C     = (has_entry && !Clear) ? head_entry.data : '0;

  rf_wq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (Clear),
    .flush     (flush),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .count     (pending),
    .head      (head),
    .head_entry(head_entry),
    .entries   (entries),
    .valid     (valid)
  );

  // Walk oldest to youngest so the last match (youngest) wins. The head
  // still counts: the register file only takes it at the edge.
  always_comb begin
    A    = rf_a;
    B    = rf_b;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (valid[slot] && entries[slot].addr == Aaddr) A = entries[slot].data;
      if (valid[slot] && entries[slot].addr == Baddr) B = entries[slot].data;
    end
  end

endmodule

// File: doc/rf_write_ctrl.md
Name: rf_write_ctrl

Overview:
- Initiator side of the register-file write port. Accepts writeback results (address, data) from the ALU/memory stages over a valid/ready handshake and buffers them in a small in-order queue.
- Drives Caddr/C/Load into the register file one entry per cycle.
- Forwards the youngest pending value onto the two read paths, so operand reads never see a stale register while writes are still queued.
- Sits between writeback and the 16x16 register file.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..8.
- AW, 4, register address width (16 registers).
- DW, 16, data width.
- R0_WRITABLE, 1, when 0, pushes to address 0 are accepted and silently dropped (never queued, never forwarded).

Ports:
- clk  in  1  system clock, rising edge
- Clear  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  writeback result valid
- in_ready  out  1  queue can accept
- in_addr  in  AW  destination register
- in_data  in  DW  result value
- wr_hold  in  1  suppress register-file writes this cycle
- Caddr  out  AW  register-file write address
- C  out  DW  register-file write data
- Load  out  1  register-file write enable
- Aaddr  in  AW  read address A (also sent to register file)
- Baddr  in  AW  read address B
- rf_a  in  DW  register-file read data A
- rf_b  in  DW  register-file read data B
- A  out  DW  forwarded operand A
- B  out  DW  forwarded operand B
- pending  out  log2(DEPTH)+1  queued entry count

Behaviour:
- Reset: while Clear=1, at each clk edge the count, head and tail pointers clear to 0.
  - Load=0, Caddr=0, C=0 and in_ready=0 while Clear is high.
  - in_ready=1 in the first cycle after Clear deasserts.
- Push: occurs at the clk edge when in_valid && in_ready.
  - in_ready = (pending != DEPTH) && !Clear; this is independent of a same-cycle pop, so there is no combinational path from pop to ready.
  - If R0_WRITABLE=0 and in_addr=0, the handshake completes but nothing is queued.
- Issue: Load = (pending != 0) && !wr_hold && !Clear.
  - Caddr and C equal the head entry whenever pending != 0; otherwise they are 0.
  - Pop occurs at the clk edge when Load=1. The register file always accepts, so no back-pressure exists beyond wr_hold.
- Latency: an entry pushed at edge N is presented with Load=1 during cycle N+1 (if not held). Minimum push-to-commit is 1 cycle.
- Throughput: 1 push plus 1 pop per cycle; pending is unchanged when both occur.
- Full/empty:
  - Push is ignored when full (in_ready=0).
  - Pop never occurs when empty.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop with pending=1: the head pops and the new entry becomes head. No bubble.
- Forwarding (combinational):
  - A = data of the youngest queued entry whose addr == Aaddr; otherwise rf_a. B is identical using Baddr/rf_b.
  - The head entry being written in the current cycle still counts as queued, since the register file updates at the edge.
  - The incoming in_* entry is NOT forwarded until it is queued.
  - When several entries match, youngest-wins is mandatory.
- flush: at the clk edge, pending goes to 0 and the pointers reset.
  - A push in the same cycle as flush is discarded.
  - The head write that is Load-high in that cycle still commits.
  - Clear has priority over flush.
- Ordering: writes commit strictly in push order. Two queued writes to the same address both commit, and the later one wins in the register file.

Decomposition:
- Shared package: RF_AW=4, RF_DW=16, RF_NREGS=16, and a typedef for the write-entry struct {addr, data}, reused by the register file and the hazard logic.
- One sub-module: rf_wq_fifo, the DEPTH-entry queue. It exposes the head entry and the full entry array plus a valid mask for the forwarding scan.
- The forwarding priority scan stays in the top module.

Test Plan:
1. Clear for 2 cycles, release, push (addr 5, 0x1234) → Load=1, Caddr=5, C=0x1234 the next cycle; pending returns to 0 one edge later.
2. Hold wr_hold=1 and push 4 entries → pending=4, in_ready=0; a 5th push is ignored. Release hold → Loads occur in order on 4 consecutive cycles.
3. Queue (3,0xAAAA) then (3,0xBBBB) under hold, Aaddr=3, rf_a=0x0000 → A=0xBBBB. After the first pop → A=0xBBBB. After the second pop → A follows rf_a.
4. pending=1, push (7,0x0F0F) in the same cycle as a pop → no bubble; the next cycle shows Load=1, Caddr=7, pending=1.
5. Under hold, queue 3 entries, then assert flush with a simultaneous push → pending=0 and no further Load. The flush-cycle head commits only if hold=0.
6. R0_WRITABLE=0, push (0,0xFFFF) → in_ready handshake completes, pending stays 0, Load never rises, and A with Aaddr=0 equals rf_a.
